// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: next-PC select encodings, opcodes, IR field
// positions and the fetch FSM state type.
package cpu_defs;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_REG    = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SA_LSB     = 6;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// Combinational next-PC selection and alignment detection.
module next_pc_logic
    import cpu_defs::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pc4,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm_ext,
    input  logic [31:0] rs_data,
    input  logic [25:0] instr_index,
    output logic [31:0] next_pc,
    output logic        misalign
);

    always_comb begin
        next_pc = pc4;
        case (pc_src)
            PC_NEXT:   next_pc = pc4;
            PC_BRANCH: next_pc = pc + 32'd4 + (imm_ext << 2);
            PC_REG:    next_pc = rs_data;
            PC_JUMP:   next_pc = {pc4[31:28], instr_index, 2'b00};
            default:   next_pc = pc4;
        endcase
    end

    assign misalign = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC and IR registers, imem req/valid handshake
// with timeout, and IR field decode for the control unit.
module fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic        IRWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] imm_ext,
    input  logic [31:0] rs_data,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic [31:0] IR,
    output logic [5:0]  Opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [15:0] imm16,
    output logic        fetch_stall,
    output logic        fetch_err,
    output logic        pc_misalign
);

    localparam logic [3:0] TIMEOUT_CNT = 4'(IMEM_TIMEOUT);

    fetch_state_t state, state_next;
    logic [3:0]   cnt, cnt_next;
    logic         ir_load, err_set, pc_update;
    logic [31:0]  next_pc;
    logic         next_misalign;

    assign PC4         = PC + 32'd4;
    assign imem_addr   = PC;
    assign fetch_stall = (state == WAIT);
    assign pc_update   = PCWre && !fetch_stall;

    assign Opcode = IR[OPCODE_LSB +: 6];
    assign rs     = IR[RS_LSB +: 5];
    assign rt     = IR[RT_LSB +: 5];
    assign rd     = IR[RD_LSB +: 5];
    assign sa     = IR[SA_LSB +: 5];
    assign imm16  = IR[15:0];

    next_pc_logic u_next_pc (
        .pc          (PC),
        .pc4         (PC4),
        .pc_src      (PCSrc),
        .imm_ext     (imm_ext),
        .rs_data     (rs_data),
        .instr_index (IR[25:0]),
        .next_pc     (next_pc),
        .misalign    (next_misalign)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ir_load    = 1'b0;
        err_set    = 1'b0;
        imem_req   = 1'b0;
        case (state)
            IDLE: begin
                imem_req = IRWre;
                cnt_next = '0;
                if (IRWre) begin
                    if (imem_valid) ir_load = 1'b1;
                    else            state_next = WAIT;
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                cnt_next = cnt + 4'd1;
                // A valid arriving on the timeout cycle still completes the fetch
                if (imem_valid) begin
                    ir_load    = 1'b1;
                    state_next = IDLE;
                end else if (cnt_next == TIMEOUT_CNT) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            PC          <= RESET_PC;
            IR          <= '0;
            fetch_err   <= 1'b0;
            pc_misalign <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            if (ir_load)   IR        <= imem_rdata;
            if (err_set)   fetch_err <= 1'b1;
            if (pc_update) PC        <= {next_pc[31:2], 2'b00};
            pc_misalign <= pc_update && next_misalign;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit: stimulus queues expected state,
// a negedge monitor pops and compares.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        PCWre, IRWre, imem_valid;
    logic [1:0]  PCSrc;
    logic [31:0] imm_ext, rs_data, imem_rdata;
    logic        imem_req, fetch_stall, fetch_err, pc_misalign;
    logic [31:0] imem_addr, PC, PC4, IR;
    logic [5:0]  Opcode;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        req;
        logic        stall;
        logic        err;
        logic        mis;
        bit          f;
        logic [5:0]  op;
        logic [4:0]  frs;
        logic [4:0]  frt;
        logic [15:0] imm;
    } exp_t;

    exp_t q[$];

    fetch_unit #(
        .RESET_PC     (32'h0000_0000),
        .IMEM_TIMEOUT (15)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .PCWre       (PCWre),
        .IRWre       (IRWre),
        .PCSrc       (PCSrc),
        .imm_ext     (imm_ext),
        .rs_data     (rs_data),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .PC          (PC),
        .PC4         (PC4),
        .IR          (IR),
        .Opcode      (Opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .sa          (sa),
        .imm16       (imm16),
        .fetch_stall (fetch_stall),
        .fetch_err   (fetch_err),
        .pc_misalign (pc_misalign)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp({e.tag, ".PC"},          PC,          e.pc);
            cmp({e.tag, ".PC4"},         PC4,         e.pc + 32'd4);
            cmp({e.tag, ".imem_addr"},   imem_addr,   e.pc);
            cmp({e.tag, ".IR"},          IR,          e.ir);
            cmp({e.tag, ".imem_req"},    32'(imem_req),    32'(e.req));
            cmp({e.tag, ".fetch_stall"}, 32'(fetch_stall), 32'(e.stall));
            cmp({e.tag, ".fetch_err"},   32'(fetch_err),   32'(e.err));
            cmp({e.tag, ".pc_misalign"}, 32'(pc_misalign), 32'(e.mis));
            if (e.f) begin
                cmp({e.tag, ".Opcode"}, 32'(Opcode), 32'(e.op));
                cmp({e.tag, ".rs"},     32'(rs),     32'(e.frs));
                cmp({e.tag, ".rt"},     32'(rt),     32'(e.frt));
                cmp({e.tag, ".imm16"},  32'(imm16),  32'(e.imm));
            end
        end
    end

    task automatic push(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                        input logic req, input logic stall, input logic err, input logic mis,
                        input bit f, input logic [5:0] op, input logic [4:0] frs,
                        input logic [4:0] frt, input logic [15:0] imm);
        exp_t e;
        e.tag = tag; e.pc = pc; e.ir = ir; e.req = req; e.stall = stall;
        e.err = err; e.mis = mis; e.f = f; e.op = op; e.frs = frs; e.frt = frt; e.imm = imm;
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Expected state visible during the current cycle, then advance one clock.
    task automatic chk(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                       input logic req, input logic stall, input logic err, input logic mis);
        push(tag, pc, ir, req, stall, err, mis, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; PCWre = 1'b0; IRWre = 1'b0; PCSrc = 2'b00;
        imm_ext = '0; rs_data = '0; imem_rdata = '0; imem_valid = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst1", 32'h0, 32'h0, 0, 0, 0, 0);
        chk("rst2", 32'h0, 32'h0, 0, 0, 0, 0);
        Reset = 1'b1;

        // Zero-wait fetch
        IRWre = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h2001_0005;
        chk("zw_req", 32'h0, 32'h0, 1, 0, 0, 0);
        IRWre = 1'b0; imem_valid = 1'b0;
        push("zw_ir", 32'h0, 32'h2001_0005, 0, 0, 0, 0, 1'b1, 6'h08, 5'd0, 5'd1, 16'h0005);

        // Advance PC to 8
        PCWre = 1'b1; PCSrc = 2'b00;
        chk("inc0", 32'h0, 32'h2001_0005, 0, 0, 0, 0);
        chk("inc4", 32'h4, 32'h2001_0005, 0, 0, 0, 0);
        PCWre = 1'b0;
        chk("inc8", 32'h8, 32'h2001_0005, 0, 0, 0, 0);

        // Wait-state fetch; PCWre asserted while stalled must be ignored
        IRWre = 1'b1;
        chk("ws_req", 32'h8, 32'h2001_0005, 1, 0, 0, 0);
        IRWre = 1'b0; PCWre = 1'b1;
        chk("ws_w1", 32'h8, 32'h2001_0005, 1, 1, 0, 0);
        chk("ws_w2", 32'h8, 32'h2001_0005, 1, 1, 0, 0);
        imem_valid = 1'b1; imem_rdata = 32'h0810_0000;
        chk("ws_w3", 32'h8, 32'h2001_0005, 1, 1, 0, 0);
        imem_valid = 1'b0; PCSrc = 2'b00;
        push("ws_done", 32'h8, 32'h0810_0000, 0, 0, 0, 0, 1'b1, 6'h02, 5'd0, 5'h10, 16'h0000);

        // jr to 0x0040_0010, then branch back by two words
        PCSrc = 2'b10; rs_data = 32'h0040_0010;
        chk("pc12", 32'hC, 32'h0810_0000, 0, 0, 0, 0);
        PCSrc = 2'b01; imm_ext = 32'hFFFF_FFFE;
        chk("jr_ok", 32'h0040_0010, 32'h0810_0000, 0, 0, 0, 0);
        PCSrc = 2'b11;
        chk("branch", 32'h0040_000C, 32'h0810_0000, 0, 0, 0, 0);
        PCSrc = 2'b10; rs_data = 32'h0000_0106;
        chk("jump", 32'h0040_0000, 32'h0810_0000, 0, 0, 0, 0);
        PCWre = 1'b0;
        chk("mis_on", 32'h0000_0104, 32'h0810_0000, 0, 0, 0, 1);
        chk("mis_off", 32'h0000_0104, 32'h0810_0000, 0, 0, 0, 0);

        // Timeout: valid never arrives
        IRWre = 1'b1;
        chk("to_req", 32'h0000_0104, 32'h0810_0000, 1, 0, 0, 0);
        IRWre = 1'b0;
        for (int i = 1; i <= 15; i++)
            chk($sformatf("to_w%0d", i), 32'h0000_0104, 32'h0810_0000, 1, 1, 0, 0);
        chk("to_err", 32'h0000_0104, 32'h0810_0000, 0, 0, 1, 0);
        chk("to_sticky", 32'h0000_0104, 32'h0810_0000, 0, 0, 1, 0);

        // Reset during WAIT, then a late valid must be ignored
        IRWre = 1'b1;
        chk("rw_req", 32'h0000_0104, 32'h0810_0000, 1, 0, 1, 0);
        IRWre = 1'b0;
        chk("rw_wait", 32'h0000_0104, 32'h0810_0000, 1, 1, 1, 0);
        Reset = 1'b0;
        chk("rw_rst", 32'h0000_0104, 32'h0810_0000, 1, 1, 1, 0);
        Reset = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        chk("rw_late", 32'h0, 32'h0, 0, 0, 0, 0);
        imem_valid = 1'b0;
        chk("rw_after", 32'h0, 32'h0, 0, 0, 0, 0);

        @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
